// File: rtl/tt_ctrl_seq.sv
// tt_ctrl_seq: walks the mux controller's ripple selection counter to a requested count
module tt_ctrl_seq #(
  parameter int HALF_CYC   = 2,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_addr,
  input  logic       req_ena,
  output logic       busy,
  output logic       done,
  output logic [9:0] cur_addr,
  output logic       ctrl_sel_rst_n,
  output logic       ctrl_sel_inc,
  output logic       ctrl_ena
);
  typedef enum logic [2:0] {RST_REL, IDLE, DISABLE, RESET, INC_HI, INC_LO, SETTLE, FINISH} state_t;
  state_t state, state_d;
  logic [9:0] tgt, rem;
  logic tgt_ena, last, ge;
  logic [15:0] tmr, tmr_ld;
  assign last = tmr == '0;
  assign ge = tgt >= cur_addr;
  always_comb begin
    state_d = state;
    case (state)
      RST_REL: state_d = IDLE;
      IDLE:    state_d = req_valid ? DISABLE : IDLE;
      DISABLE: state_d = !ge ? RESET : (tgt == cur_addr) ? SETTLE : INC_HI;
      RESET:   state_d = !last ? RESET : (rem == '0) ? SETTLE : INC_HI;
      INC_HI:  state_d = last ? INC_LO : INC_HI;
      INC_LO:  state_d = !last ? INC_LO : (rem == 10'd1) ? SETTLE : INC_HI;
      SETTLE:  state_d = last ? FINISH : SETTLE;
      FINISH:  state_d = IDLE;
      default: state_d = RST_REL;
    endcase
    tmr_ld = state_d == RESET ? 16'(RST_CYC - 1) :
             (state_d == INC_HI || state_d == INC_LO) ? 16'(HALF_CYC - 1) :
             state_d == SETTLE ? 16'(SETTLE_CYC - 1) : '0;
  end
  // Outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RST_REL;
      tmr            <= '0;
      rem            <= '0;
      tgt            <= '0;
      tgt_ena        <= 1'b0;
      cur_addr       <= '0;
      req_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state <= state_d;
      tmr   <= (state_d != state) ? tmr_ld : tmr - 16'd1;
      if (state == IDLE && req_valid) begin
        tgt     <= req_addr;
        tgt_ena <= req_ena;
      end
      if (state == DISABLE) rem <= ge ? tgt - cur_addr : tgt;
      else if (state == INC_LO && last) rem <= rem - 10'd1;
      if (state_d == RESET) cur_addr <= '0;
      else if (state_d == INC_HI && state != INC_HI) cur_addr <= cur_addr + 10'd1;
      req_ready      <= state_d == IDLE;
      busy           <= state_d != IDLE;
      done           <= state_d == FINISH;
      ctrl_sel_rst_n <= state_d != RESET;
      ctrl_sel_inc   <= state_d == INC_HI;
      ctrl_ena       <= state_d == DISABLE ? 1'b0 : state_d == FINISH ? tgt_ena : ctrl_ena;
    end
  end
endmodule

// File: tb/tb_tt_ctrl_seq.sv
// tb_tt_ctrl_seq: scoreboard bench for tt_ctrl_seq with a ripple-counter model on the select wires
module tb_tt_ctrl_seq;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ena = 1'b0;
  logic [9:0] req_addr = '0;
  logic req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  logic [9:0] cur_addr;
  tt_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_ena(req_ena), .busy(busy), .done(done),
    .cur_addr(cur_addr), .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
  );
  always #5 clk = ~clk;
  typedef struct {logic [9:0] addr; logic ena; int lat; int pulses; int rlow;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, tot_p = 0;
  int acc_cyc = 0, p0 = 0, rlow = 0, elow = 0, rdy_hi = 0;
  logic in_seq = 1'b0;
  logic [9:0] model = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge ctrl_sel_inc) tot_p <= tot_p + 1;
  always @(posedge ctrl_sel_inc or negedge ctrl_sel_rst_n)
    model <= !ctrl_sel_rst_n ? 10'd0 : model + 10'd1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
  // Monitor: measures each sequence from accept to done and checks it against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) in_seq = 1'b0;
    else begin
      if (done) begin
        chk("sb_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("cur_addr", cur_addr, e.addr);
          chk("ctrl_ena", ctrl_ena, e.ena);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("pulses", tot_p - p0, e.pulses);
          chk("rst_low_cycles", rlow, e.rlow);
          chk("ena_low_cycles", elow, e.lat);
          chk("ready_while_busy", rdy_hi, 0);
          chk("model_vs_cur", model, cur_addr);
        end
        in_seq = 1'b0;
      end else if (in_seq) begin
        if (!ctrl_sel_rst_n) rlow++;
        if (!ctrl_ena) elow++;
        if (req_ready) rdy_hi++;
      end
      if (req_valid && req_ready) begin
        in_seq = 1'b1;
        acc_cyc = cyc + 1;
        p0 = tot_p;
        rlow = 0;
        elow = 0;
        rdy_hi = 0;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [9:0] a, input logic e, input int lat, input int np,
                      input int rl, input bit wait_done, input bit hold);
    int t = 0;
    while (!req_ready && t < 20000) begin step(); t++; end
    if (!req_ready) begin chk("ready_timeout", 0, 1); return; end
    q.push_back('{a, e, lat, np, rl});
    req_valid = 1'b1;
    req_addr = a;
    req_ena = e;
    step();
    req_valid = hold;
    if (!wait_done) return;
    t = 0;
    while (!done && t < 20000) begin
      req_addr = req_addr + 10'd7;
      req_ena = ~req_ena;
      step();
      t++;
    end
    req_valid = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    step();
  endtask
  initial begin
    int t;
    repeat (3) step();
    chk("reset_outputs", {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready, cur_addr}, 0);
    rst_n = 1'b1;
    chk("rst_rel_outputs", {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready, cur_addr}, 0);
    step();
    chk("idle_after_rel", {ctrl_sel_rst_n, req_ready, busy}, 3'b110);
    send(10'd3, 1'b1, 17, 3, 0, 1, 0);
    send(10'd3, 1'b1, 5, 0, 0, 1, 0);
    send(10'd1, 1'b1, 13, 1, 4, 1, 0);
    send(10'd1023, 1'b1, 4093, 1022, 0, 1, 0);
    send(10'd0, 1'b0, 9, 0, 4, 1, 0);
    repeat (3) step();
    chk("ena_hold", ctrl_ena, 0);
    send(10'd40, 1'b1, 0, 0, 0, 0, 0);
    t = 0;
    while (!(ctrl_sel_inc && tot_p - p0 == 5) && t < 1000) begin step(); t++; end
    chk("fifth_pulse_reached", tot_p - p0, 5);
    rst_n = 1'b0;
    q.delete();
    step();
    chk("midwalk_reset_outputs", {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready, cur_addr}, 0);
    chk("model_cleared", model, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_midreset", req_ready, 1);
    send(10'd2, 1'b1, 13, 2, 0, 1, 0);
    send(10'd10, 1'b1, 37, 8, 0, 1, 1);
    repeat (4) step();
    chk("sb_drained", q.size(), 0);
    chk("idle_at_end", {busy, req_ready}, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
